sparten_chunk_scheduler: RTL and testbench
==========================================

// Module: sparten_chunk_scheduler
// PURPOSE
//  Sequences one sparse dot-product job (N chunks of CHUNK_SIZE) across NUM_CU sparse compute
//  units. Requests chunk loads from the chunk loader and pulses each CU's enable. Collects the
//  per-chunk 2Q-bit partial results and sums them into one ACC_W-bit dot product. Sits between
//  the layer controller (job/result handshakes) and the compute-unit array.
// PARAMETERS
//  NUM_CU      4    number of compute units scheduled (>=1)
//  Q           8    quantization bits; CU result width is 2*Q
//  MAX_CHUNKS  64   maximum chunks per job
//  ACC_W       32   job accumulator / result width (>= 2*Q + clog2(MAX_CHUNKS))
// PORTS
//  clk              in   1                 clock
//  rst_n            in   1                 async active-low reset
//  job_valid        in   1                 job offer
//  job_ready        out  1                 high only in IDLE
//  job_num_chunks   in   clog2(MAX_CHUNKS)+1  chunk count; 0 is legal (empty job)
//  chunk_req_valid  out  1                 load request for chunk_req_idx into CU chunk_req_cu
//  chunk_req_ready  in   1                 loader accepts; CU operands stable until that CU's done
//  chunk_req_idx    out  clog2(MAX_CHUNKS) chunk index, issued 0,1,2,... in order
//  chunk_req_cu     out  max(1,clog2(NUM_CU)) target CU
//  cu_enable        out  NUM_CU            one-cycle start pulse per CU
//  cu_done          in   NUM_CU            one-cycle completion pulse per CU
//  cu_result        in   NUM_CU*2*Q        flattened CU results, CU i at [i*2Q +: 2Q]
//  res_valid        out  1                 job result valid; held until res_ready
//  res_ready        in   1                 consumer accepts
//  res_data         out  ACC_W             job dot product
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 except job_ready=1; accumulator, counters and busy mask 0.
//    Reset mid-job abandons the job with no result. CUs share rst_n.
//  - FSM: IDLE -> DISPATCH on job_valid&&job_ready; count latched, acc/counters cleared.
//    DISPATCH -> DRAIN when issued==count. DRAIN -> OUTPUT when completed==count.
//    OUTPUT -> IDLE on res_ready. count==0: DISPATCH->DRAIN->OUTPUT with res_data=0.
//  - Dispatch: chunk_req_valid=1 in DISPATCH when issued<count and busy mask has a free CU.
//    chunk_req_cu = lowest-index free CU, registered. Idx/cu held stable while valid&&!ready.
//    On handshake: issued++, busy[cu] set, cu_enable[cu] pulses the NEXT cycle.
//  - Completion: cu_done[i] counts only if busy[i]; otherwise it is ignored.
//    A counted done clears busy[i], adds zero-extended cu_result[i] to acc, and does completed++.
//    Multiple dones in one cycle are all summed and counted that cycle.
//    A CU freed in cycle t is selectable in cycle t+1.
//  - Arithmetic: unsigned, acc wraps modulo 2^ACC_W; no saturation.
//  - res_data = acc, registered at DRAIN->OUTPUT; res_valid and res_data stable while !res_ready.
//  - Latency: job accept at t0 -> first chunk_req_valid at t1 -> first cu_enable at t(handshake)+1.
//    Last counted done at tn -> res_valid at tn+1.
// STRUCTURE
//  - sparten_pkg: sched_state_e {IDLE,DISPATCH,DRAIN,OUTPUT}; width helpers (CIDX_W, CU_W).
//  - Sub-module sparten_cu_pick: parameterised lowest-free priority encoder (busy -> idx, any_free).
//  - Done accumulation: combinational sum of masked results plus popcount of counted dones.
// TESTING (NUM_CU=4, Q=8, ACC_W=32)
//  - job 1 chunk, CU0 result 16'h0010 -> one req (idx0,cu0), cu_enable=4'b0001 once,
//    res_data=16, done->res_valid 1 cycle.
//  - job 6, loader always ready, results 1..6 -> idx 0..3 to CU0..3; idx4/5 to first freed CUs;
//    res_data=21.
//  - all 4 CUs done same cycle, each 16'hFFFF -> completed+=4 that cycle, res_data=32'h3FFFC.
//  - chunk_req_ready low 5 cycles -> req_valid/idx/cu stable, no cu_enable; proceeds on ready.
//  - res_ready low 10 cycles -> res_valid/data held, job_ready=0, job_valid ignored.
//    Spurious cu_done on an idle CU -> no count change.
//  - job_num_chunks=0 -> no req, res_valid with res_data=0; rst_n low in DRAIN -> all outputs reset,
//    next job (2 chunks, results 3,4) gives 7.

Source files
------------

// File: rtl/sparten_pkg.sv
// Shared types and width helpers for the sparse dot-product chunk scheduler.
package sparten_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DRAIN,
        OUTPUT
    } sched_state_e;

    // Chunk index width for a given maximum chunk count.
    function automatic int cidx_w(input int max_chunks);
        return (max_chunks > 1) ? $clog2(max_chunks) : 1;
    endfunction

    // Compute-unit select width; a single CU still needs a 1-bit select.
    function automatic int cu_w(input int num_cu);
        return (num_cu > 1) ? $clog2(num_cu) : 1;
    endfunction

endpackage

// File: rtl/sparten_chunk_scheduler_cu_pick.sv
// Lowest-index free compute unit selector: busy mask in, index and any-free flag out.
module sparten_cu_pick
    import sparten_pkg::*;
#(
    parameter int NUM_CU = 4,
    parameter int SEL_W  = cu_w(NUM_CU)
) (
    input  logic [NUM_CU-1:0] busy,
    output logic [SEL_W-1:0]  idx,
    output logic              any_free
);

    // Scanning downward lets the lowest free index win.
    always_comb begin
        idx      = '0;
        any_free = 1'b0;
        for (int i = NUM_CU - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                idx      = SEL_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sparten_chunk_scheduler.sv
// Dispatches the chunks of one sparse dot-product job over the CU array and
// accumulates the per-chunk partial results into a single job result.
module sparten_chunk_scheduler
    import sparten_pkg::*;
#(
    parameter int NUM_CU     = 4,
    parameter int Q          = 8,
    parameter int MAX_CHUNKS = 64,
    parameter int ACC_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic [cidx_w(MAX_CHUNKS):0] job_num_chunks,
    output logic                        chunk_req_valid,
    input  logic                        chunk_req_ready,
    output logic [cidx_w(MAX_CHUNKS)-1:0] chunk_req_idx,
    output logic [cu_w(NUM_CU)-1:0]     chunk_req_cu,
    output logic [NUM_CU-1:0]           cu_enable,
    input  logic [NUM_CU-1:0]           cu_done,
    input  logic [NUM_CU*2*Q-1:0]       cu_result,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [ACC_W-1:0]            res_data
);

    localparam int IDX_W = cidx_w(MAX_CHUNKS);
    localparam int CNT_W = IDX_W + 1;
    localparam int SEL_W = cu_w(NUM_CU);
    localparam int RES_W = 2 * Q;

    sched_state_e      state, state_next;
    logic [CNT_W-1:0]  count, issued, completed, completed_next, done_cnt;
    logic [NUM_CU-1:0] busy, counted, hs_mask;
    logic [ACC_W-1:0]  acc, acc_next, done_sum;
    logic [SEL_W-1:0]  pick_idx, req_cu_hold;
    logic              any_free, req_hold, handshake;

    sparten_cu_pick #(.NUM_CU(NUM_CU), .SEL_W(SEL_W)) u_pick (
        .busy     (busy),
        .idx      (pick_idx),
        .any_free (any_free)
    );

    // A stalled offer keeps its CU even if a lower CU frees up meanwhile.
    assign job_ready       = (state == IDLE);
    assign chunk_req_valid = (state == DISPATCH) && (issued < count) && any_free;
    assign chunk_req_cu    = req_hold ? req_cu_hold : pick_idx;
    assign chunk_req_idx   = issued[IDX_W-1:0];
    assign handshake       = chunk_req_valid && chunk_req_ready;
    assign hs_mask         = handshake ? (NUM_CU'(1) << chunk_req_cu) : '0;
    assign counted         = cu_done & busy;

    always_comb begin
        done_sum = '0;
        done_cnt = '0;
        for (int i = 0; i < NUM_CU; i++) begin
            if (counted[i]) begin
                done_sum = done_sum + ACC_W'(cu_result[i*RES_W +: RES_W]);
                done_cnt = done_cnt + CNT_W'(1);
            end
        end
    end

    assign acc_next       = acc + done_sum;
    assign completed_next = completed + done_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // DRAIN looks at this cycle's dones so the result follows the last done by one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (job_valid)                 state_next = DISPATCH;
            DISPATCH: if (issued == count)           state_next = DRAIN;
            DRAIN:    if (completed_next == count)   state_next = OUTPUT;
            OUTPUT:   if (res_ready)                 state_next = IDLE;
            default:                                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            issued      <= '0;
            completed   <= '0;
            busy        <= '0;
            acc         <= '0;
            cu_enable   <= '0;
            req_hold    <= 1'b0;
            req_cu_hold <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
        end else begin
            busy        <= (busy & ~counted) | hs_mask;
            acc         <= acc_next;
            completed   <= completed_next;
            cu_enable   <= hs_mask;
            req_hold    <= chunk_req_valid && !chunk_req_ready;
            req_cu_hold <= chunk_req_cu;
            if (handshake) issued <= issued + CNT_W'(1);
            if (state == IDLE && job_valid) begin
                count     <= job_num_chunks;
                issued    <= '0;
                completed <= '0;
                acc       <= '0;
            end
            if (state == DRAIN && state_next == OUTPUT) begin
                res_valid <= 1'b1;
                res_data  <= acc_next;
            end else if (state == OUTPUT && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sparten_chunk_scheduler.sv
// Randomized self-checking bench: CU models and a job-level reference model drive and check the scheduler.
module tb_sparten_chunk_scheduler;

    localparam int NUM_CU     = 4;
    localparam int Q          = 8;
    localparam int MAX_CHUNKS = 64;
    localparam int ACC_W      = 32;
    localparam int BUDGET     = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [6:0]  job_num_chunks = '0;
    logic        chunk_req_valid;
    logic        chunk_req_ready = 1'b0;
    logic [5:0]  chunk_req_idx;
    logic [1:0]  chunk_req_cu;
    logic [3:0]  cu_enable;
    logic [3:0]  cu_done = '0;
    logic [63:0] cu_result = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;

    int compared = 0;
    int mismatched = 0;
    logic [15:0] res_tab [MAX_CHUNKS];

    sparten_chunk_scheduler #(
        .NUM_CU(NUM_CU), .Q(Q), .MAX_CHUNKS(MAX_CHUNKS), .ACC_W(ACC_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_num_chunks  (job_num_chunks),
        .chunk_req_valid (chunk_req_valid),
        .chunk_req_ready (chunk_req_ready),
        .chunk_req_idx   (chunk_req_idx),
        .chunk_req_cu    (chunk_req_cu),
        .cu_enable       (cu_enable),
        .cu_done         (cu_done),
        .cu_result       (cu_result),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest_free(input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (!b[i]) return i;
        return 0;
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) res_tab[i] = 16'($urandom);
    endtask

    // One job end to end. ready_mode: 0 always, 1 random, 2 stall stall_idx for 5 cycles.
    task automatic run_job(input int n, input int ready_mode, input int stall_idx,
                           input bit sync_done, input bit spurious, input int hold,
                           input bit abort_in_drain, input bit busy_job_valid);
        int next_idx = 0;
        int done_count = 0;
        int result_due = -1;
        int last_hs = -10;
        int stall_left = 5;
        bit pending = 1'b0;
        bit early = 1'b0;
        bit finished = 1'b0;
        bit exp_valid;
        bit rdy;
        logic [1:0]  held_cu = '0;
        logic [1:0]  exp_cu;
        logic [3:0]  m_busy = '0;
        logic [3:0]  exp_en = '0;
        logic [3:0]  new_en;
        logic [3:0]  legit;
        logic [3:0]  drive;
        logic [31:0] exp_sum = '0;
        int          done_at [4];
        logic [15:0] cu_res [4];

        for (int i = 0; i < 4; i++) begin
            done_at[i] = -1;
            cu_res[i]  = '0;
        end
        compared++;
        if (job_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL job_ready_idle: got %b want 1", job_ready);
        end
        job_valid = 1'b1;
        job_num_chunks = 7'(n);
        step();
        job_valid = 1'b0;
        if (n == 0) result_due = 2;

        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            if (cyc == result_due) begin
                compared++;
                if (res_valid !== 1'b1 || res_data !== exp_sum) begin
                    mismatched++;
                    $display("[TB] FAIL result: got valid=%b data=%h want valid=1 data=%h",
                             res_valid, res_data, exp_sum);
                end
                finished = 1'b1;
                break;
            end
            if (res_valid) early = 1'b1;
            if (abort_in_drain && n > 0 && next_idx == n && cyc == last_hs + 2) begin
                finished = 1'b1;
                break;
            end

            compared++;
            if (cu_enable !== exp_en) begin
                mismatched++;
                $display("[TB] FAIL cu_enable: got %b want %b (cycle %0d)", cu_enable, exp_en, cyc);
            end
            exp_valid = (next_idx < n) && (m_busy != 4'hF);
            compared++;
            if (chunk_req_valid !== exp_valid) begin
                mismatched++;
                $display("[TB] FAIL req_valid: got %b want %b (cycle %0d)", chunk_req_valid, exp_valid, cyc);
            end

            new_en = '0;
            legit = '0;
            drive = '0;
            rdy = 1'b0;
            cu_result = {$urandom, $urandom};
            for (int i = 0; i < 4; i++) begin
                if (m_busy[i] && (sync_done ? (next_idx == n && cyc >= last_hs + 3)
                                            : (done_at[i] == cyc))) begin
                    legit[i] = 1'b1;
                    cu_result[i*16 +: 16] = cu_res[i];
                end
            end
            if (spurious && $urandom_range(2) == 0) begin
                int k = int'($urandom_range(3));
                if (!m_busy[k]) begin
                    drive[k] = 1'b1;
                    cu_result[k*16 +: 16] = 16'hFFFF;
                end
            end

            if (chunk_req_valid) begin
                exp_cu = pending ? held_cu : 2'(lowest_free(m_busy));
                compared++;
                if (chunk_req_idx !== 6'(next_idx) || chunk_req_cu !== exp_cu) begin
                    mismatched++;
                    $display("[TB] FAIL req_target: got idx=%0d cu=%0d want idx=%0d cu=%0d",
                             chunk_req_idx, chunk_req_cu, next_idx, exp_cu);
                end
                case (ready_mode)
                    0: rdy = 1'b1;
                    1: rdy = 1'($urandom_range(1));
                    default: begin
                        if (next_idx == stall_idx && stall_left > 0) begin
                            rdy = 1'b0;
                            stall_left--;
                        end else begin
                            rdy = 1'b1;
                        end
                    end
                endcase
                if (rdy) begin
                    if (next_idx < n) begin
                        new_en = 4'b1 << exp_cu;
                        cu_res[exp_cu] = res_tab[next_idx];
                        done_at[exp_cu] = cyc + 3 + int'($urandom_range(3));
                        next_idx++;
                        last_hs = cyc;
                    end
                    pending = 1'b0;
                end else begin
                    pending = 1'b1;
                    held_cu = exp_cu;
                end
            end else begin
                pending = 1'b0;
            end
            chunk_req_ready = rdy;

            m_busy = (m_busy & ~legit) | new_en;
            for (int i = 0; i < 4; i++) begin
                if (legit[i]) begin
                    exp_sum = exp_sum + 32'(cu_res[i]);
                    done_count++;
                end
            end
            if (legit != 0 && done_count == n) result_due = cyc + 1;
            exp_en = new_en;
            cu_done = legit | drive;
            step();
        end

        cu_done = '0;
        chunk_req_ready = 1'b0;
        if (!finished) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL timeout: job of %0d chunks got no result within %0d cycles", n, BUDGET);
            return;
        end
        compared++;
        if (early) begin
            mismatched++;
            $display("[TB] FAIL early_result: got res_valid before last done, want it only after");
        end
        if (abort_in_drain) return;

        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            job_valid = busy_job_valid;
            job_num_chunks = 7'd3;
            cu_done = spurious ? 4'(1 << $urandom_range(3)) : 4'b0;
            cu_result = {$urandom, $urandom};
            step();
            compared++;
            if (res_valid !== 1'b1 || res_data !== exp_sum || job_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL result_hold: got valid=%b data=%h job_ready=%b want 1 %h 0",
                         res_valid, res_data, job_ready, exp_sum);
            end
        end
        job_valid = 1'b0;
        cu_done = '0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        compared++;
        if (res_valid !== 1'b0 || job_ready !== 1'b1 || chunk_req_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL release: got valid=%b job_ready=%b req_valid=%b want 0 1 0",
                     res_valid, job_ready, chunk_req_valid);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        compared++;
        if ({job_ready, chunk_req_valid, cu_enable, res_valid, res_data, chunk_req_idx, chunk_req_cu}
            !== {1'b1, 1'b0, 4'b0, 1'b0, 32'b0, 6'b0, 2'b0}) begin
            mismatched++;
            $display("[TB] FAIL %s: got jr=%b rv=%b en=%b resv=%b data=%h idx=%0d cu=%0d want 1 0 0000 0 0 0 0",
                     name, job_ready, chunk_req_valid, cu_enable, res_valid, res_data,
                     chunk_req_idx, chunk_req_cu);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_chunk();
        res_tab[0] = 16'h0010;
        run_job(1, 0, -1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_six_chunks();
        for (int i = 0; i < 6; i++) res_tab[i] = 16'(i + 1);
        run_job(6, 0, -1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_all_done_same_cycle();
        for (int i = 0; i < 4; i++) res_tab[i] = 16'hFFFF;
        run_job(4, 0, -1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_req_stall();
        fill_random(3);
        run_job(3, 2, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        fill_random(6);
        run_job(6, 2, 4, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_result_hold();
        fill_random(5);
        run_job(5, 1, -1, 1'b0, 1'b1, 10, 1'b0, 1'b1);
    endtask

    task automatic test_empty_job();
        run_job(0, 0, -1, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_drain();
        fill_random(3);
        run_job(3, 0, -1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_in_drain");
        step();
        rst_n = 1'b1;
        step();
        res_tab[0] = 16'd3;
        res_tab[1] = 16'd4;
        run_job(2, 0, -1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 6; j++) begin
            int n = int'($urandom_range(1, 20));
            fill_random(n);
            run_job(n, 1, -1, 1'b0, 1'b1, int'($urandom_range(3)), 1'b0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single_chunk();
        test_six_chunks();
        test_all_done_same_cycle();
        test_req_stall();
        test_result_hold();
        test_empty_job();
        test_reset_in_drain();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
